// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone bridge. A byte-stream command ('W'/'R', a 3-byte address and,
// for writes, DATA_BYTES data bytes, all MSB-first) becomes a single pipelined
// Wishbone cycle. The result is returned on the TX byte stream: 'K' for a
// completed write, the read data for a read, 'T' on ack timeout, '?' for an
// unknown opcode.
module uart_wb_bridge #(
  parameter int ADDR_BITS      = 24,
  parameter int DATA_BITS      = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  // UART receive stream
  input  logic [7:0]              i_rx_tdata,
  input  logic                    i_rx_tvalid,
  output logic                    o_rx_tready,
  // UART transmit stream
  output logic [7:0]              o_tx_tdata,
  output logic                    o_tx_tvalid,
  input  logic                    i_tx_tready,
  // Wishbone master
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [ADDR_BITS-1:0]    o_wb_addr,
  output logic [DATA_BITS-1:0]    o_wb_data,
  output logic [DATA_BITS/8-1:0]  o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [DATA_BITS-1:0]    i_wb_data,
  // Status
  output logic                    o_busy
);

  localparam int DATA_BYTES = DATA_BITS / 8;
  localparam int CNT_W      = $clog2(DATA_BYTES + 1) + 1;

  // The ack wait counter is 16 bits wide; the limit is taken modulo that width.
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  localparam logic [7:0] OP_WRITE  = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ   = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_TMO   = 8'h54;  // 'T'
  localparam logic [7:0] RSP_BADOP = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    REQ,
    WAIT_ACK,
    RESP
  } state_e;

  state_e                 state_q,    state_d;
  logic                   is_write_q, is_write_d;
  logic [23:0]            addr_q,     addr_d;
  logic [DATA_BITS-1:0]   wdata_q,    wdata_d;
  logic [DATA_BITS-1:0]   tx_sh_q,    tx_sh_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic                   cyc_q,      cyc_d;
  logic                   stb_q,      stb_d;
  logic                   we_q,       we_d;
  logic [DATA_BYTES-1:0]  sel_q,      sel_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q,  tx_data_d;
  logic [15:0]            tmo_q,      tmo_d;
  logic                   rx_ready_q, rx_ready_d;

  logic                   rx_fire;
  logic                   tx_fire;
  logic [15:0]            tmo_inc;

  assign rx_fire = i_rx_tvalid & rx_ready_q;
  assign tx_fire = tx_valid_q & i_tx_tready;
  // Saturating increment: the wait counter never wraps back to zero.
  assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

  // Next-state and datapath decode for the command/request/response sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves
    // a signal unassigned, which would infer a latch.
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_sh_d    = tx_sh_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tmo_d      = tmo_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (i_rx_tdata == OP_WRITE || i_rx_tdata == OP_READ) begin
            is_write_d = (i_rx_tdata == OP_WRITE);
            addr_d     = '0;
            cnt_d      = '0;
            state_d    = ADDR;
          end else begin
            tx_data_d  = RSP_BADOP;
            tx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = RESP;
          end
        end
      end

      ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[15:0], i_rx_tdata};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(2)) begin
            cnt_d = '0;
            if (is_write_q) begin
              state_d = WDATA;
            end else begin
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              we_d    = 1'b0;
              sel_d   = '1;
              state_d = REQ;
            end
          end
        end
      end

      WDATA: begin
        if (rx_fire) begin
          wdata_d = {wdata_q[DATA_BITS-9:0], i_rx_tdata};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = '1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        // Request fields stay frozen until the slave stops stalling.
        if (!i_wb_stall) begin
          stb_d   = 1'b0;
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        tmo_d = tmo_inc;
        if (i_wb_ack) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = '0;
          tx_valid_d = 1'b1;
          state_d    = RESP;
          if (is_write_q) begin
            tx_data_d = RSP_OK;
            cnt_d     = '0;
          end else begin
            tx_data_d = i_wb_data[DATA_BITS-1 -: 8];
            tx_sh_d   = {i_wb_data[DATA_BITS-9:0], 8'h00};
            cnt_d     = CNT_W'(DATA_BYTES - 1);
          end
        end else if (tmo_inc >= TIMEOUT_LIM) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = '0;
          tx_data_d  = RSP_TMO;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = RESP;
        end
      end

      RESP: begin
        // cnt_q holds the number of bytes still to send after the current one.
        if (tx_fire) begin
          if (cnt_q == '0) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            state_d    = IDLE;
          end else begin
            tx_data_d = tx_sh_q[DATA_BITS-1 -: 8];
            tx_sh_d   = {tx_sh_q[DATA_BITS-9:0], 8'h00};
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // RX ready is registered from the next state so it is low throughout reset
  // and rises on the first edge after release.
  always_comb begin
    rx_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: the wide data registers are reset too, because every output they
    // drive must read zero while reset is held.
    if (i_rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_sh_q    <= '0;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_sh_q    <= tx_sh_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign o_rx_tready = rx_ready_q;
  assign o_tx_tdata  = tx_data_q;
  assign o_tx_tvalid = tx_valid_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = ADDR_BITS'(addr_q);
  assign o_wb_data   = wdata_q;
  assign o_wb_sel    = sel_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: write, read, stall with TX backpressure,
// ack timeout, bad opcode and reset in the middle of a write command.
module tb_uart_wb_bridge;

  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 128;
  localparam int DATA_BYTES = DATA_BITS / 8;

  logic                   clk;
  logic                   rst;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   wb_cyc;
  logic                   wb_stb;
  logic                   wb_we;
  logic [ADDR_BITS-1:0]   wb_addr;
  logic [DATA_BITS-1:0]   wb_wdata;
  logic [DATA_BYTES-1:0]  wb_sel;
  logic                   wb_stall;
  logic                   wb_ack;
  logic [DATA_BITS-1:0]   wb_rdata;
  logic                   busy;

  // Slave-model and monitor state (written only by the monitor process)
  logic                   slave_ack;
  logic                   extra_ack;
  int                     ack_cd;
  int                     acc_cnt;
  int                     cyc_cycles;
  int                     stb_run, last_stb_run;
  int                     wait_run, last_wait_run;
  int                     stab_err;
  int                     hold_err;
  logic                   prev_stb;
  logic [ADDR_BITS+DATA_BITS+DATA_BYTES:0] prev_req;
  logic                   prev_hold;
  logic [7:0]             prev_tx;
  logic [ADDR_BITS-1:0]   cap_addr;
  logic [DATA_BITS-1:0]   cap_data;
  logic [DATA_BYTES-1:0]  cap_sel;
  logic                   cap_we;
  logic [7:0]             tx_log[$];

  // Knobs written only by the main sequence
  logic                   ack_en;
  int                     ack_delay;
  logic                   tx_toggle;

  int                     n_vec;
  int                     n_miss;

  assign wb_ack = slave_ack | extra_ack;

  uart_wb_bridge #(
    .ADDR_BITS      (ADDR_BITS),
    .DATA_BITS      (DATA_BITS),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_tdata  (rx_data),
    .i_rx_tvalid (rx_valid),
    .o_rx_tready (rx_ready),
    .o_tx_tdata  (tx_data),
    .o_tx_tvalid (tx_valid),
    .i_tx_tready (tx_ready),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .o_wb_we     (wb_we),
    .o_wb_addr   (wb_addr),
    .o_wb_data   (wb_wdata),
    .o_wb_sel    (wb_sel),
    .i_wb_stall  (wb_stall),
    .i_wb_ack    (wb_ack),
    .i_wb_data   (wb_rdata),
    .o_busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wishbone slave and TX sink, evaluated on the falling edge: the values seen
  // here are exactly the ones the DUT samples at the next rising edge.
  initial begin
    slave_ack = 1'b0; ack_cd = 0; tx_ready = 1'b1;
    acc_cnt = 0; cyc_cycles = 0; stab_err = 0; hold_err = 0;
    stb_run = 0; last_stb_run = 0; wait_run = 0; last_wait_run = 0;
    prev_stb = 1'b0; prev_req = '0; prev_hold = 1'b0; prev_tx = 8'h00;
    cap_addr = '0; cap_data = '0; cap_sel = '0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_cd > 0) begin
        ack_cd    = ack_cd - 1;
        slave_ack = (ack_cd == 0);
      end else begin
        slave_ack = 1'b0;
      end
      tx_ready = tx_toggle ? ~tx_ready : 1'b1;

      if (wb_cyc && wb_stb && !wb_stall) begin
        acc_cnt  = acc_cnt + 1;
        cap_addr = wb_addr;
        cap_data = wb_wdata;
        cap_sel  = wb_sel;
        cap_we   = wb_we;
        if (ack_en) ack_cd = ack_delay;
      end
      if (wb_cyc) cyc_cycles = cyc_cycles + 1;

      if (wb_stb) stb_run = stb_run + 1;
      else if (stb_run > 0) begin last_stb_run = stb_run; stb_run = 0; end
      if (wb_cyc && !wb_stb) wait_run = wait_run + 1;
      else if (wait_run > 0) begin last_wait_run = wait_run; wait_run = 0; end

      if (wb_stb && prev_stb && ({wb_we, wb_addr, wb_wdata, wb_sel} != prev_req))
        stab_err = stab_err + 1;
      prev_stb = wb_stb;
      prev_req = {wb_we, wb_addr, wb_wdata, wb_sel};

      if (prev_hold && (!tx_valid || tx_data != prev_tx)) hold_err = hold_err + 1;
      prev_hold = tx_valid && !tx_ready;
      prev_tx   = tx_data;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    end
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic taken;
    taken    = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !taken; i++) begin
      if (rx_ready) taken = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    if (!taken) check("rx_byte_accepted", taken, 1'b1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [23:0] addr);
    send_byte(op);
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
  endtask

  task automatic send_data(input logic [DATA_BITS-1:0] d);
    for (int i = DATA_BYTES - 1; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    check(tag, done, 1'b1);
  endtask

  function automatic logic [DATA_BITS-1:0] tx_bytes(input int from);
    logic [DATA_BITS-1:0] v;
    v = '0;
    for (int i = from; i < tx_log.size(); i++) v = {v[DATA_BITS-9:0], tx_log[i]};
    return v;
  endfunction

  function automatic logic [9:0] all_outputs();
    return {wb_cyc, wb_stb, wb_we, |wb_addr, |wb_wdata, |wb_sel,
            tx_valid, |tx_data, rx_ready, busy};
  endfunction

  initial begin
    int acc0, tx0, cyc0, stab0, hold0;
    n_vec = 0; n_miss = 0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    wb_stall = 1'b0; wb_rdata = '0; extra_ack = 1'b0;
    ack_en = 1'b1; ack_delay = 2; tx_toggle = 1'b0;

    // Reset state and first edge after release
    repeat (3) tick();
    check("reset_outputs", all_outputs(), 10'b0);
    rst = 1'b0;
    tick();
    check("rdy_after_release", rx_ready, 1'b1);
    check("idle_after_release", busy, 1'b0);

    // Write: 'W' 000005, data 00..0F, ack two cycles after acceptance
    acc0 = acc_cnt; tx0 = tx_log.size();
    send_cmd(8'h57, 24'h000005);
    send_data(128'h000102030405060708090A0B0C0D0E0F);
    wait_idle("wr_done");
    check("wr_accepts", acc_cnt - acc0, 1);
    check("wr_stb_cycles", last_stb_run, 1);
    check("wr_we", cap_we, 1'b1);
    check("wr_addr", cap_addr, 24'h000005);
    check("wr_data", cap_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("wr_sel", cap_sel, 16'hFFFF);
    check("wr_tx_count", tx_log.size() - tx0, 1);
    check("wr_tx_byte", tx_bytes(tx0), 8'h4B);

    // Read: 'R' 000100, slave returns A5 in every byte
    acc0 = acc_cnt; tx0 = tx_log.size();
    wb_rdata = {16{8'hA5}};
    send_cmd(8'h52, 24'h000100);
    wait_idle("rd_done");
    check("rd_accepts", acc_cnt - acc0, 1);
    check("rd_we", cap_we, 1'b0);
    check("rd_addr", cap_addr, 24'h000100);
    check("rd_sel", cap_sel, 16'hFFFF);
    check("rd_tx_count", tx_log.size() - tx0, DATA_BYTES);
    check("rd_tx_bytes", tx_bytes(tx0), {16{8'hA5}});

    // Stall for 10 cycles, TX ready toggling every cycle
    acc0 = acc_cnt; tx0 = tx_log.size(); stab0 = stab_err; hold0 = hold_err;
    wb_rdata  = 128'h00112233445566778899AABBCCDDEEFF;
    wb_stall  = 1'b1;
    tx_toggle = 1'b1;
    send_cmd(8'h52, 24'h000200);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        if (wb_stb) seen = 1'b1;
        else tick();
      end
      check("st_stb_seen", seen, 1'b1);
    end
    repeat (10) tick();
    wb_stall = 1'b0;
    wait_idle("st_done");
    tx_toggle = 1'b0;
    check("st_accepts", acc_cnt - acc0, 1);
    check("st_stb_cycles", last_stb_run, 11);
    check("st_req_stable", stab_err - stab0, 0);
    check("st_addr", cap_addr, 24'h000200);
    check("st_tx_count", tx_log.size() - tx0, DATA_BYTES);
    check("st_tx_bytes", tx_bytes(tx0), 128'h00112233445566778899AABBCCDDEEFF);
    check("st_tx_hold", hold_err - hold0, 0);

    // Timeout: no ack, then a late ack that must be ignored
    acc0 = acc_cnt; tx0 = tx_log.size();
    ack_en = 1'b0;
    send_cmd(8'h52, 24'h000007);
    wait_idle("to_done");
    check("to_accepts", acc_cnt - acc0, 1);
    check("to_wait_cycles", last_wait_run, 20);
    check("to_tx_count", tx_log.size() - tx0, 1);
    check("to_tx_byte", tx_bytes(tx0), 8'h54);
    cyc0 = cyc_cycles;
    extra_ack = 1'b1;
    tick();
    extra_ack = 1'b0;
    repeat (3) tick();
    check("late_ack_busy", busy, 1'b0);
    check("late_ack_tx", tx_log.size() - tx0, 1);
    check("late_ack_cyc", cyc_cycles - cyc0, 0);
    check("late_ack_rdy", rx_ready, 1'b1);
    ack_en = 1'b1;

    // Bad opcode, then a normal read
    tx0 = tx_log.size(); cyc0 = cyc_cycles;
    send_byte(8'h41);
    wait_idle("bad_done");
    check("bad_tx_count", tx_log.size() - tx0, 1);
    check("bad_tx_byte", tx_bytes(tx0), 8'h3F);
    check("bad_no_cyc", cyc_cycles - cyc0, 0);
    acc0 = acc_cnt; tx0 = tx_log.size();
    wb_rdata = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    send_cmd(8'h52, 24'h000ABC);
    wait_idle("bad_rd_done");
    check("bad_rd_accepts", acc_cnt - acc0, 1);
    check("bad_rd_addr", cap_addr, 24'h000ABC);
    check("bad_rd_tx_bytes", tx_bytes(tx0), 128'hDEADBEEF0123456789ABCDEFCAFEF00D);

    // Reset after 7 write data bytes, then a fresh write
    acc0 = acc_cnt;
    send_cmd(8'h57, 24'h000009);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h11 * (i + 1)));
    check("mid_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", all_outputs(), 10'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("mid_rdy_after_release", rx_ready, 1'b1);
    check("mid_no_accept", acc_cnt - acc0, 0);
    tx0 = tx_log.size();
    send_cmd(8'h57, 24'h00000A);
    send_data(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    wait_idle("fresh_done");
    check("fresh_accepts", acc_cnt - acc0, 1);
    check("fresh_we", cap_we, 1'b1);
    check("fresh_addr", cap_addr, 24'h00000A);
    check("fresh_data", cap_data, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    check("fresh_tx_byte", tx_bytes(tx0), 8'h4B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global guard against a hung sequence
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24, the Wishbone address width; it is sent as 3 UART bytes.
REQ-002 SHALL have parameter DATA_BITS, default 128, the Wishbone data width; DATA_BYTES = DATA_BITS/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, the maximum number of cycles to wait for an ack.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: i_clk, input, 1, the single clock; i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have the UART receive stream: i_rx_tdata in 8; i_rx_tvalid in 1; o_rx_tready out 1.
REQ-006 SHALL have the UART transmit stream: o_tx_tdata out 8; o_tx_tvalid out 1; i_tx_tready in 1.
REQ-007 SHALL have the Wishbone master outputs o_wb_cyc, o_wb_stb and o_wb_we (out 1 each); o_wb_addr out ADDR_BITS; o_wb_data out DATA_BITS; o_wb_sel out DATA_BYTES.
REQ-008 SHALL have the Wishbone master inputs i_wb_stall in 1; i_wb_ack in 1; i_wb_data in DATA_BITS.
REQ-009 SHALL have o_busy, out 1, high whenever the state is not IDLE.

Function
REQ-010 SHALL use states IDLE, ADDR, WDATA, REQ, WAIT_ACK and RESP.
REQ-011 SHALL accept an RX byte only on a cycle where i_rx_tvalid and o_rx_tready are both high; o_rx_tready is high only in IDLE, ADDR and WDATA.
REQ-012 SHALL move from IDLE to ADDR on byte 0x57 ('W', write) or 0x52 ('R', read), latching the opcode.
REQ-013 SHALL, on any other byte in IDLE, load 0x3F ('?') into RESP as a 1-byte response and then return to IDLE.
REQ-014 SHALL, in ADDR, shift in 3 bytes MSB-first into o_wb_addr (zero-extended or truncated to ADDR_BITS); after the 3rd byte it goes to WDATA for a write or to REQ for a read.
REQ-015 SHALL, in WDATA, shift in DATA_BYTES bytes MSB-first into o_wb_data and then go to REQ.
REQ-016 SHALL, on entry to REQ, assert o_wb_cyc=1, o_wb_stb=1 and o_wb_we equal to the opcode (1 for 'W'), with o_wb_sel all ones.
REQ-017 SHALL hold o_wb_stb and all request fields stable while i_wb_stall=1.
REQ-018 SHALL treat the request as accepted on the first cycle with stb=1 and stall=0; stb drops on the next cycle and the state becomes WAIT_ACK.
REQ-019 SHALL ignore i_wb_ack outside WAIT_ACK, including the acceptance cycle itself.
REQ-020 SHALL, in WAIT_ACK on i_wb_ack=1, drop o_wb_cyc on the next cycle, capture i_wb_data for a read, and go to RESP.
REQ-021 SHALL count WAIT_ACK cycles; when the count reaches TIMEOUT_CYCLES it drops o_wb_cyc, loads the 1-byte response 0x54 ('T') and goes to RESP.
REQ-022 SHALL count 16 bits wide, saturate (never wrap), and clear the count on entry to WAIT_ACK.
REQ-023 SHALL, in RESP, send a 1-byte response 0x4B ('K') for a completed write, or DATA_BYTES bytes of captured read data MSB-first for a read.
REQ-024 SHALL hold o_tx_tdata stable while o_tx_tvalid=1 and i_tx_tready=0, and advance to the next byte only on a valid&ready handshake.
REQ-025 SHALL return to IDLE after the last response byte handshakes; o_tx_tvalid is low on the following cycle.
REQ-026 SHALL never have more than one Wishbone request outstanding.
REQ-027 SHALL discard RX bytes arriving in REQ, WAIT_ACK or RESP by holding o_rx_tready low, so they stay in the UART.
REQ-028 SHALL have no limit on the gap between command bytes.

Reset
REQ-029 SHALL, while i_rst=1, immediately force the state to IDLE and all outputs to 0: o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_tx_tvalid, o_tx_tdata, o_rx_tready and o_busy.
REQ-030 SHALL, on reset mid-transaction, drop cyc/stb asynchronously, discard any partially received command, and leave any outstanding ack to be ignored after release.
REQ-031 SHALL assert o_rx_tready=1 on the first clock edge after i_rst is released.

Verification
REQ-032 SHALL be tested with a write: RX 'W',00,00,05 then bytes 0x00..0x0F, stall=0, ack 2 cycles after acceptance -> one stb cycle with we=1, addr=0x000005, data=0x000102030405060708090A0B0C0D0E0F, sel=0xFFFF, then TX 0x4B.
REQ-033 SHALL be tested with a read: RX 'R',00,01,00, i_wb_data=0xA5 repeated 16 times at ack -> stb with we=0, addr=0x000100, then TX sixteen 0xA5 bytes.
REQ-034 SHALL be tested with stall and backpressure: stall held for 10 cycles and i_tx_tready toggled every other cycle -> stb and addr stable for 11 cycles, exactly one acceptance, no TX byte lost or duplicated.
REQ-035 SHALL be tested with a timeout, using TIMEOUT_CYCLES=20: no ack -> cyc drops after 20 WAIT_ACK cycles and TX 0x54; a late ack is then ignored.
REQ-036 SHALL be tested with a bad opcode: RX 0x41 -> TX 0x3F, no Wishbone activity, and the next 'R' command is processed normally.
REQ-037 SHALL be tested with reset mid-WDATA, after 7 data bytes -> all outputs 0 immediately; a fresh complete 'W' command afterwards produces a correct write.
